// File: rtl/cache_fill_fsm_pkg.sv
// Shared cache definitions: address slicing widths, block geometry and fill FSM states.
package cache_pkg;

  localparam int OFFSET_W        = 4;
  localparam int INDEX_W         = 6;
  localparam int TAG_W           = 6;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int CNT_W           = $clog2(WORDS_PER_BLOCK) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } fill_state_t;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Clear/increment word counter that saturates at MAX; used for request issue and data receive.
module fill_counter
  import cache_pkg::*;
#(
  parameter int MAX = WORDS_PER_BLOCK,
  parameter int W   = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Data cache miss handler: fetches one block as sequential word reads, streams the
// returned words into the data array, then writes the tag/valid entry once.
//
// state | meaning
// IDLE  | waiting for miss_detected; counters held clear
// FILL  | issuing word requests and accepting returned words
// TAG   | one-cycle tag/valid write of the filled block
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int WORD_W          = 16,
  parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  output logic                               fsm_busy,
  output logic                               mem_read_en,
  output logic [ADDR_W-1:0]                  memory_address,
  input  logic                               memory_data_valid,
  input  logic [WORD_W-1:0]                  memory_data,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] cache_word_index,
  output logic [WORD_W-1:0]                  cache_data,
  output logic                               write_tag_array,
  output logic [ADDR_W-1:0]                  fill_block_addr
);

  localparam int CW             = $clog2(WORDS_PER_BLOCK) + 1;
  localparam int IW             = $clog2(WORDS_PER_BLOCK);
  localparam int BYTES_PER_WORD = WORD_W / 8;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFFSET_W) - 1);

  fill_state_t       state_q, state_d;
  logic              fsm_busy_q, fsm_busy_d;
  logic              mem_read_en_q, mem_read_en_d;
  logic [ADDR_W-1:0] memory_address_q, memory_address_d;
  logic              write_tag_q, write_tag_d;
  logic [ADDR_W-1:0] fill_block_addr_q, fill_block_addr_d;

  logic [CW-1:0]     issue_cnt, recv_cnt;
  logic              cnt_clr, issue_inc;
  logic              accept, last_word;
  logic [ADDR_W-1:0] next_off;

  fill_counter #(.MAX(WORDS_PER_BLOCK), .W(CW)) u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (issue_inc),
    .cnt (issue_cnt)
  );

  fill_counter #(.MAX(WORDS_PER_BLOCK), .W(CW)) u_recv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (accept),
    .cnt (recv_cnt)
  );

  assign accept    = (state_q == FILL) && memory_data_valid && (recv_cnt < CW'(WORDS_PER_BLOCK));
  assign last_word = accept && (recv_cnt == CW'(WORDS_PER_BLOCK - 1));
  // Registered request path: the offset is for the word following the one on the bus now.
  assign next_off  = ADDR_W'((int'(issue_cnt) + 1) * BYTES_PER_WORD);

  always_comb begin
    state_d           = state_q;
    mem_read_en_d     = 1'b0;
    memory_address_d  = '0;
    write_tag_d       = 1'b0;
    fill_block_addr_d = fill_block_addr_q;
    cnt_clr           = 1'b0;
    issue_inc         = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (miss_detected) begin
          state_d           = FILL;
          fill_block_addr_d = miss_address & ~OFF_MASK;
          mem_read_en_d     = 1'b1;
          memory_address_d  = miss_address & ~OFF_MASK;
        end
      end
      FILL: begin
        if (issue_cnt < CW'(WORDS_PER_BLOCK)) begin
          issue_inc = 1'b1;
        end
        if (issue_cnt < CW'(WORDS_PER_BLOCK - 1)) begin
          mem_read_en_d    = 1'b1;
          memory_address_d = fill_block_addr_q + next_off;
        end
        if (last_word) begin
          state_d     = TAG;
          write_tag_d = 1'b1;
        end
      end
      TAG: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    fsm_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= IDLE;
      fsm_busy_q        <= 1'b0;
      mem_read_en_q     <= 1'b0;
      memory_address_q  <= '0;
      write_tag_q       <= 1'b0;
      fill_block_addr_q <= '0;
    end else begin
      state_q           <= state_d;
      fsm_busy_q        <= fsm_busy_d;
      mem_read_en_q     <= mem_read_en_d;
      memory_address_q  <= memory_address_d;
      write_tag_q       <= write_tag_d;
      fill_block_addr_q <= fill_block_addr_d;
    end
  end

  assign fsm_busy         = fsm_busy_q;
  assign mem_read_en      = mem_read_en_q;
  assign memory_address   = memory_address_q;
  assign write_tag_array  = write_tag_q;
  assign fill_block_addr  = fill_block_addr_q;
  assign write_data_array = accept;
  assign cache_word_index = accept ? recv_cnt[IW-1:0] : '0;
  assign cache_data       = accept ? memory_data : '0;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: directed fill table, reset abort, and randomized fills
// checked against a timeline computed from the request/return rules.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        write_data_array;
  logic [2:0]  cache_word_index;
  logic [15:0] cache_data;
  logic        write_tag_array;
  logic [15:0] fill_block_addr;

  cache_fill_fsm #(.ADDR_W(16), .WORD_W(16), .WORDS_PER_BLOCK(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .write_data_array  (write_data_array),
    .cache_word_index  (cache_word_index),
    .cache_data        (cache_data),
    .write_tag_array   (write_tag_array),
    .fill_block_addr   (fill_block_addr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Current fill: word i returns at relative cycle i+1+lat, plus gap_l if i >= gap_w.
  logic [15:0] cur_addr, base;
  int          lat, gap_w, gap_l, t_tag, busy_cnt;
  bit          spur;
  logic [15:0] wdata [8];

  task automatic step(input int c, input bit miss_in);
    bit          v;
    logic [15:0] d;
    int          wi;
    @(negedge clk);
    v  = 1'b0;
    d  = 16'($urandom);
    wi = 0;
    for (int i = 0; i < 8; i++) begin
      if (c == i + 1 + lat + ((i >= gap_w) ? gap_l : 0)) begin
        v  = 1'b1;
        d  = wdata[i];
        wi = i;
      end
    end
    if (spur && c == t_tag) v = 1'b1;
    miss_detected     = miss_in;
    miss_address      = (c == 0) ? cur_addr : 16'($urandom);
    memory_data_valid = v;
    memory_data       = d;
    #1;
    chk("fsm_busy", 32'(fsm_busy), 32'(c >= 1 && c <= t_tag));
    chk("mem_read_en", 32'(mem_read_en), 32'(c >= 1 && c <= 8));
    if (c >= 1 && c <= 8) chk("memory_address", 32'(memory_address), 32'(16'(base + 16'(2 * (c - 1)))));
    chk("write_data_array", 32'(write_data_array), 32'(v && c < t_tag));
    if (v && c < t_tag) begin
      chk("cache_word_index", 32'(cache_word_index), 32'(wi));
      chk("cache_data", 32'(cache_data), 32'(d));
    end
    chk("write_tag_array", 32'(write_tag_array), 32'(c == t_tag));
    if (c == t_tag) chk("fill_block_addr", 32'(fill_block_addr), 32'(base));
    if (fsm_busy) busy_cnt++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      miss_detected     = 1'b0;
      miss_address      = 16'($urandom);
      memory_data_valid = 1'($urandom);
      memory_data       = 16'($urandom);
      #1;
      chk("idle_busy", 32'(fsm_busy), 32'd0);
      chk("idle_read", 32'(mem_read_en), 32'd0);
      chk("idle_write", 32'(write_data_array), 32'd0);
      chk("idle_tag", 32'(write_tag_array), 32'd0);
    end
  endtask

  task automatic run_fill(input logic [15:0] a, input logic [15:0] b, input int l, input int gw,
                          input int gl, input bit h, input bit sp, input bit directed, input int abort_c);
    int last;
    cur_addr = a; base = b; lat = l; gap_w = gw; gap_l = gl; spur = sp;
    for (int i = 0; i < 8; i++) wdata[i] = directed ? 16'(16'hA000 + i) : 16'($urandom);
    t_tag    = 9 + l + ((gw < 8) ? gl : 0);
    busy_cnt = 0;
    last     = (abort_c >= 0) ? abort_c : t_tag;
    for (int c = 0; c <= last; c++) step(c, (c == 0) || (h && c <= t_tag));
    if (abort_c < 0) chk("busy_cycles", 32'(busy_cnt), 32'(8 + l + 1 + ((gw < 8) ? gl : 0)));
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] base;
    int          lat;
    int          gap_w;
    int          gap_l;
    bit          hold;
    bit          spur;
    int          idle_after;
  } vec_t;

  vec_t vecs [5];

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(fsm_busy), 32'd0);
    chk({tag, "_read"}, 32'(mem_read_en), 32'd0);
    chk({tag, "_addr"}, 32'(memory_address), 32'd0);
    chk({tag, "_write"}, 32'(write_data_array), 32'd0);
    chk({tag, "_index"}, 32'(cache_word_index), 32'd0);
    chk({tag, "_data"}, 32'(cache_data), 32'd0);
    chk({tag, "_tag"}, 32'(write_tag_array), 32'd0);
    chk({tag, "_fill_addr"}, 32'(fill_block_addr), 32'd0);
  endtask

  initial begin
    logic [15:0] ra;
    rst               = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = '0;
    memory_data_valid = 1'b0;
    memory_data       = '0;

    vecs[0] = '{16'h1234, 16'h1230, 4, 8, 0, 1'b0, 1'b0, 1};
    vecs[1] = '{16'hFFFE, 16'hFFF0, 4, 8, 0, 1'b0, 1'b0, 1};
    vecs[2] = '{16'h0102, 16'h0100, 4, 4, 2, 1'b0, 1'b0, 1};
    vecs[3] = '{16'h2222, 16'h2220, 3, 8, 0, 1'b1, 1'b1, 0};
    vecs[4] = '{16'h5555, 16'h5550, 2, 8, 0, 1'b0, 1'b0, 1};

    @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    for (int v = 0; v < 5; v++) begin
      run_fill(vecs[v].addr, vecs[v].base, vecs[v].lat, vecs[v].gap_w, vecs[v].gap_l,
               vecs[v].hold, vecs[v].spur, 1'b1, -1);
      idle(vecs[v].idle_after);
    end

    // Abort after the 5th word has been written, then a clean fill.
    run_fill(16'h7A5C, 16'h7A50, 4, 8, 0, 1'b0, 1'b0, 1'b1, 9);
    @(negedge clk);
    miss_detected     = 1'b0;
    memory_data_valid = 1'b1;
    memory_data       = 16'hBEEF;
    #1;
    chk("busy_before_rst", 32'(fsm_busy), 32'd1);
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    #1;
    chk("rst_held_busy", 32'(fsm_busy), 32'd0);
    rst               = 1'b1;
    memory_data_valid = 1'b0;
    idle(2);
    run_fill(16'h0040, 16'h0040, 4, 8, 0, 1'b0, 1'b0, 1'b1, -1);
    idle(1);

    repeat (12) begin
      ra = 16'($urandom);
      run_fill(ra, ra & 16'hFFF0, $urandom_range(1, 6), $urandom_range(0, 8), $urandom_range(0, 3),
               1'($urandom), 1'($urandom), 1'b0, -1);
      idle($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss handler for the 2-way data cache. On a miss reported by the data cache, it reads the 16-byte block from pipelined main memory as 8 sequential 16-bit words. Each returned word is steered into the data array. It then issues one write of the tag/valid entry into the metadata array. It sits directly downstream of the data cache's miss output and stalls the pipeline while the fill is in progress.

## Interface
Parameters:
- ADDR_W, 16, byte address width
- WORD_W, 16, memory and data-array word width
- WORDS_PER_BLOCK, 8, words per cache block; power of two

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- miss_detected  in  1  level from data cache: access at miss_address missed
- miss_address  in  ADDR_W  address of the missing access
- fsm_busy  out  1  fill in progress; pipeline stall
- mem_read_en  out  1  one memory read request this cycle
- memory_address  out  ADDR_W  request address
- memory_data_valid  in  1  memory_data carries a returned word
- memory_data  in  WORD_W  returned word
- write_data_array  out  1  write cache_data into data array this cycle
- cache_word_index  out  3  word slot within block (log2 WORDS_PER_BLOCK)
- cache_data  out  WORD_W  word to write (equal to memory_data)
- write_tag_array  out  1  write tag/valid for the filled block this cycle
- fill_block_addr  out  ADDR_W  latched block base (miss_address with low 4 bits zero)

## Operation
- States are IDLE, FILL and TAG. Reset state is IDLE.
- IDLE:
  - If miss_detected is sampled high, latch base = {miss_address[15:4], 4'b0}.
  - Clear the issue counter and receive counter, then go to FILL.
- FILL, request issue:
  - While issue_cnt < 8, drive mem_read_en=1 and memory_address = base + 2*issue_cnt, then increment issue_cnt.
  - This issues one request per cycle with no gaps.
- FILL, data return:
  - Each cycle with memory_data_valid=1 and recv_cnt < 8 drives write_data_array=1, cache_word_index=recv_cnt and cache_data=memory_data, then increments recv_cnt.
  - A return may coincide with an issue; both proceed.
- FILL to TAG: taken on the cycle in which the 8th word is accepted.
- TAG: drive write_tag_array=1 for exactly one cycle, then go to IDLE.
- fsm_busy = (state != IDLE).
- All outputs are registered, except write_data_array, cache_word_index and cache_data, which are combinational from memory_data_valid, state and recv_cnt.
- Boundary rules:
  - miss_detected is ignored outside IDLE.
  - memory_data_valid is ignored in IDLE, in TAG, and once recv_cnt = 8.
  - Counters saturate at 8; there is no wrap-around.
  - A miss sampled in the same cycle TAG returns to IDLE is not accepted until the next cycle in IDLE.
- Reset mid-fill: asynchronous return to IDLE, and all outputs go to 0 immediately. Memory shares rst, so no stale returns arrive after reset.

## Timing
- Reset values: fsm_busy, mem_read_en, write_data_array, write_tag_array = 0. memory_address, cache_word_index, cache_data, fill_block_addr = 0.
- The cycle after miss_detected is sampled in IDLE: fsm_busy=1 and the first request (word 0) is driven.
- Requests occupy 8 consecutive cycles, R1..R8.
- Memory latency L means word i returns in cycle R(i+1)+L.
- TAG is the cycle after the last return. IDLE follows one cycle later.
- Total busy cycles = 8 + L + 1 for a back-to-back return stream. With L=4 this is 13.
- Gaps in memory_data_valid extend FILL cycle-for-cycle. There is no timeout.

## Structure
- Shared package cache_pkg holds:
  - OFFSET_W=4, INDEX_W=6, TAG_W=6
  - WORDS_PER_BLOCK
  - the fill_state_t enum {IDLE, FILL, TAG}
- The data cache uses the same package for tag/index slicing of fill_block_addr.
- One sub-module, fill_counter: a 4-bit clear/increment counter saturating at WORDS_PER_BLOCK, on rst. It is instantiated twice, for issue and receive.

## Test plan
- Reset, then miss at 0x1234, L=4:
  - Requests at 0x1230, 0x1232, …, 0x123E on 8 consecutive cycles.
  - Words 0xA000..0xA007 written to indices 0..7.
  - write_tag_array pulses once with fill_block_addr=0x1230.
  - fsm_busy high for 13 cycles.
- Miss at 0xFFFE: base 0xFFF0, last request 0xFFFE, no address overflow.
- Returns with 2-cycle gaps between words 3 and 4:
  - FILL extends by 2 cycles.
  - Indices stay contiguous 0..7.
  - Tag write follows the 8th word.
- miss_detected held high through the fill, plus a 9th spurious memory_data_valid during TAG:
  - No second fill starts until IDLE.
  - No extra data write occurs.
  - A new fill starts on the following miss.
- rst asserted low after 5 words: all outputs go to 0 asynchronously and state is IDLE. After release, a miss at 0x0040 performs a complete, clean fill.
- Miss asserted together with the TAG cycle: no acceptance in TAG. The fill starts on the following IDLE cycle.
